// File: rtl/tone_pkg.sv
// Shared definitions for the tone decoder.
// Holds the note code type, the NONE marker code, the 17-bit period width,
// the FSM state encoding and a constant function producing the nominal
// period (in clock cycles) of each note code for a given clock frequency.
package tone_pkg;

    typedef logic [3:0] note_t;

    // Codes 11..14 are unused by the song ROM; 14 marks "no table note".
    localparam note_t NOTE_NONE = 4'd14;

    localparam int PERIOD_W = 17;
    localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCK    = 2'd2
    } state_t;

    // Tone frequency in Hz for each note code, 0 for unused codes.
    function automatic int unsigned note_freq(input int unsigned code);
        case (code)
            0:       return 415;
            1:       return 440;
            2:       return 494;
            3:       return 523;
            4:       return 587;
            5:       return 659;
            6:       return 698;
            7:       return 784;
            8:       return 880;
            9:       return 988;
            10:      return 1046;
            15:      return 392;
            default: return 0;
        endcase
    endfunction

    // Integer-truncated period in clock cycles; 0 for unused codes.
    function automatic logic [PERIOD_W-1:0] nominal_period(input int unsigned clk_hz,
                                                           input int unsigned code);
        int unsigned f;
        f = note_freq(code);
        if (f == 0) begin
            return '0;
        end
        return PERIOD_W'(clk_hz / f);
    endfunction

endpackage

// File: rtl/tone_period_matcher.sv
// Combinational period -> note code lookup.
// Each table entry matches when |period - nominal| <= nominal >> TOL_SHIFT.
// A saturated period, or no matching entry, yields NOTE_NONE. At the default
// tolerance the windows do not overlap; the lowest code would win otherwise.
// Ports:
//   period  in   17  measured period in clock cycles
//   code    out  4   matching note code or NOTE_NONE
module tone_period_matcher
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned TOL_SHIFT = 6
) (
    input  logic [PERIOD_W-1:0] period,
    output logic [3:0]          code
);

    logic [15:0] hit;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_note
            localparam logic [PERIOD_W-1:0] NOM = nominal_period(CLK_HZ, gi);
            localparam logic [PERIOD_W-1:0] TOL = NOM >> TOL_SHIFT;
            logic [PERIOD_W-1:0] diff;

            assign diff    = (period >= NOM) ? (period - NOM) : (NOM - period);
            assign hit[gi] = (NOM != '0) && (diff <= TOL);
        end
    endgenerate

    always_comb begin
        code = NOTE_NONE;
        if (period != PERIOD_MAX) begin
            for (int i = 15; i >= 0; i--) begin
                if (hit[i]) begin
                    code = note_t'(i);
                end
            end
        end
    end

endmodule

// File: rtl/tone_decoder.sv
// Measures the period of an incoming square wave and decodes it into the
// 4-bit note code used by the song ROM.
// Optional build macro: TONE_DUTY_CHECK_EN -- when defined, the high time of
// each period is counted and a period whose high time lies outside
// [P/4, 3P/4] is classified as NONE.
// Ports:
//   clk         in   1   system clock
//   rst         in   1   synchronous reset, active-high
//   tone_in     in   1   asynchronous square-wave input
//   note        out  4   decoded note code (held while note_valid)
//   note_valid  out  1   a confirmed table note is present
//   note_stb    out  1   one-cycle pulse on note change / note_valid rise
//   period      out  17  last measured period in clock cycles (saturating)
module tone_decoder
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned TOL_SHIFT   = 6,
    parameter int unsigned CONFIRM     = 3,
    parameter int unsigned SILENCE_CYC = 2_500_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tone_in,
    output logic [3:0]          note,
    output logic                note_valid,
    output logic                note_stb,
    output logic [PERIOD_W-1:0] period
);

    localparam int CW = $clog2(CONFIRM + 1);
    localparam logic [CW-1:0]       CONF_N   = CW'(CONFIRM);
    localparam logic [CW-1:0]       CONF_ONE = CW'(1);
    localparam logic [PERIOD_W-1:0] SILENCE  = PERIOD_W'(SILENCE_CYC);
    localparam logic [PERIOD_W-1:0] CNT_ONE  = PERIOD_W'(1);

    logic                sync1_reg, sync2_reg, sync3_reg, edge_reg;
    logic [PERIOD_W-1:0] count_reg;
    state_t              state_reg, state_next;
    note_t               cand_reg, cand_next;
    logic [CW-1:0]       conf_reg, conf_next;
    note_t               note_reg, note_next;
    logic                valid_reg, valid_next;
    logic                stb_reg, stb_next;
    logic [PERIOD_W-1:0] period_reg, period_next;
    note_t               match_code, cls;
    logic                timeout;

    tone_period_matcher #(
        .CLK_HZ    (CLK_HZ),
        .TOL_SHIFT (TOL_SHIFT)
    ) u_matcher (
        .period (count_reg),
        .code   (match_code)
    );

`ifdef TONE_DUTY_CHECK_EN
    // High time of the current period; the edge cycle itself is high.
    logic [PERIOD_W-1:0] high_reg;
    logic [PERIOD_W+1:0] hi4, p1, p3;

    always_ff @(posedge clk) begin
        if (rst) begin
            high_reg <= '0;
        end else if (edge_reg) begin
            high_reg <= CNT_ONE;
        end else if (sync3_reg && (high_reg != PERIOD_MAX)) begin
            high_reg <= high_reg + CNT_ONE;
        end
    end

    assign hi4 = {high_reg, 2'b00};
    assign p1  = {2'b00, count_reg};
    assign p3  = p1 + {1'b0, count_reg, 1'b0};
    assign cls = ((hi4 < p1) || (hi4 > p3)) ? NOTE_NONE : match_code;
`else
    assign cls = match_code;
`endif

    // Edge wins over a coincident timeout: the count restarts instead.
    assign timeout = (count_reg == SILENCE) && !edge_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            sync3_reg  <= 1'b0;
            edge_reg   <= 1'b0;
            count_reg  <= '0;
            state_reg  <= IDLE;
            cand_reg   <= NOTE_NONE;
            conf_reg   <= '0;
            note_reg   <= '0;
            valid_reg  <= 1'b0;
            stb_reg    <= 1'b0;
            period_reg <= '0;
        end else begin
            sync1_reg  <= tone_in;
            sync2_reg  <= sync1_reg;
            sync3_reg  <= sync2_reg;
            edge_reg   <= sync2_reg && !sync3_reg;
            if (edge_reg) begin
                count_reg <= CNT_ONE;
            end else if (count_reg != PERIOD_MAX) begin
                count_reg <= count_reg + CNT_ONE;
            end
            state_reg  <= state_next;
            cand_reg   <= cand_next;
            conf_reg   <= conf_next;
            note_reg   <= note_next;
            valid_reg  <= valid_next;
            stb_reg    <= stb_next;
            period_reg <= period_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cand_next   = cand_reg;
        conf_next   = conf_reg;
        note_next   = note_reg;
        valid_next  = valid_reg;
        stb_next    = 1'b0;
        period_next = period_reg;

        if (edge_reg) begin
            case (state_reg)
                IDLE: begin
                    // First edge after silence only starts the period count.
                    state_next = ACQUIRE;
                    conf_next  = '0;
                end
                default: begin
                    period_next = count_reg;
                    cand_next   = cls;
                    if (cls == cand_reg) begin
                        conf_next = (conf_reg >= CONF_N) ? CONF_N : (conf_reg + CONF_ONE);
                    end else begin
                        conf_next = CONF_ONE;
                    end
                    if (conf_next == CONF_N) begin
                        if (state_reg == ACQUIRE) begin
                            if (cls != NOTE_NONE) begin
                                state_next = LOCK;
                                note_next  = cls;
                                valid_next = 1'b1;
                                stb_next   = 1'b1;
                            end
                        end else if (cls == NOTE_NONE) begin
                            state_next = ACQUIRE;
                            valid_next = 1'b0;
                        end else if (cls != note_reg) begin
                            note_next = cls;
                            stb_next  = 1'b1;
                        end
                    end
                end
            endcase
        end else if (timeout) begin
            state_next = IDLE;
            valid_next = 1'b0;
            conf_next  = '0;
        end
    end

    assign note       = note_reg;
    assign note_valid = valid_reg;
    assign note_stb   = stb_reg;
    assign period     = period_reg;

endmodule

// File: tb/tb_tone_decoder.sv
// Bench for tone_decoder. A scaled clock frequency keeps periods short.
// A cycle-level reference model tracks pin edges, measured periods, recent
// classifications and output expectations; outputs are compared every cycle.
module tb_tone_decoder;

    localparam int CLK_HZ  = 200_000;
    localparam int TOLS    = 6;
    localparam int CONF    = 3;
    localparam int SIL     = 3000;
    localparam int NONE    = 14;
    localparam int PMAX    = 131071;
    localparam int LAT     = 3;
    localparam int FREQS [16] = '{415, 440, 494, 523, 587, 659, 698, 784,
                                  880, 988, 1046, 0, 0, 0, 0, 392};

    logic        clk = 1'b0;
    logic        rst;
    logic        tone_in;
    logic [3:0]  note;
    logic        note_valid;
    logic        note_stb;
    logic [16:0] period;

    int checks   = 0;
    int failures = 0;
    int printed  = 0;
    int stb_cnt  = 0;

    tone_decoder #(
        .CLK_HZ      (CLK_HZ),
        .TOL_SHIFT   (TOLS),
        .CONFIRM     (CONF),
        .SILENCE_CYC (SIL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tone_in    (tone_in),
        .note       (note),
        .note_valid (note_valid),
        .note_stb   (note_stb),
        .period     (period)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (printed < 40) begin
                printed++;
                $display("FAIL %s: got %0d expected %0d", name, act, exp);
            end
        end
    endtask

    // Note code for a measured period with given high time.
    function automatic int classify(input int p, input int hi);
        int nom;
        int tol;
        int d;
        if (p >= PMAX) return NONE;
`ifdef TONE_DUTY_CHECK_EN
        if ((hi * 4 < p) || (hi * 4 > 3 * p)) return NONE;
`endif
        for (int i = 0; i < 16; i++) begin
            if (FREQS[i] != 0) begin
                nom = CLK_HZ / FREQS[i];
                tol = nom >> TOLS;
                d   = (p > nom) ? p - nom : nom - p;
                if (d <= tol) return i;
            end
        end
        return NONE;
    endfunction

    // ---------------- reference model ----------------
    int  cyc = 0;
    int  flag_t[$];
    int  flag_hi[$];
    int  hist[$];
    bit  prev_pin;
    int  hi_acc;
    int  last_flag;
    bit  have_flag;
    int  mode;          // 0 silent, 1 searching, 2 locked
    bit  model_on = 1'b0;
    int  exp_note, exp_valid, exp_stb, exp_period;

    always @(posedge clk) begin
        bit flag;
        int h;
        int p;
        int c;
        bit same;
        cyc++;
        exp_stb = 0;
        if (rst) begin
            flag_t.delete();
            flag_hi.delete();
            hist.delete();
            prev_pin   = 1'b0;
            hi_acc     = 0;
            have_flag  = 1'b0;
            mode       = 0;
            exp_note   = 0;
            exp_valid  = 0;
            exp_period = 0;
            model_on   = 1'b1;
        end else begin
            flag = (flag_t.size() > 0) && (flag_t[0] == cyc);
            h = 0;
            if (flag) begin
                void'(flag_t.pop_front());
                h = flag_hi.pop_front();
            end
            if (tone_in && !prev_pin) begin
                flag_t.push_back(cyc + LAT);
                flag_hi.push_back(hi_acc);
                hi_acc = 1;
            end else if (tone_in) begin
                hi_acc++;
            end
            prev_pin = tone_in;

            if (flag) begin
                if (mode == 0) begin
                    mode = 1;
                    hist.delete();
                end else begin
                    p = cyc - last_flag;
                    if (p > PMAX) p = PMAX;
                    exp_period = p;
                    c = classify(p, h);
                    hist.push_back(c);
                    if (hist.size() > CONF) void'(hist.pop_front());
                    same = (hist.size() == CONF);
                    foreach (hist[k]) if (hist[k] != c) same = 1'b0;
                    if (same) begin
                        if (mode == 1 && c != NONE) begin
                            mode = 2; exp_note = c; exp_valid = 1; exp_stb = 1;
                        end else if (mode == 2 && c == NONE) begin
                            mode = 1; exp_valid = 0;
                        end else if (mode == 2 && c != exp_note) begin
                            exp_note = c; exp_stb = 1;
                        end
                    end
                end
                last_flag = cyc;
                have_flag = 1'b1;
            end else if (have_flag && (cyc - last_flag == SIL)) begin
                mode = 0;
                exp_valid = 0;
                hist.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("cyc_note", 32'(note), 32'(exp_note));
            chk("cyc_valid", 32'(note_valid), 32'(exp_valid));
            chk("cyc_stb", 32'(note_stb), 32'(exp_stb));
            chk("cyc_period", 32'(period), 32'(exp_period));
            if (note_stb === 1'b1) stb_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wave(input int per, input int hi, input int reps);
        for (int r = 0; r < reps; r++) begin
            tone_in = 1'b1;
            repeat (hi) @(posedge clk);
            #1;
            tone_in = 1'b0;
            repeat (per - hi) @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tone_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_note", 32'(note), 0);
        chk("rst_valid", 32'(note_valid), 0);
        chk("rst_stb", 32'(note_stb), 0);
        chk("rst_period", 32'(period), 0);

        // Pin the model's classifier with hand-computed codes.
        chk("model_440", classify(454, 227), 1);
        chk("model_523", classify(382, 191), 3);
        chk("model_600", classify(333, 166), NONE);
        chk("model_392", classify(510, 255), 15);

        // 1: 440 Hz locks after three measured periods.
        stb_cnt = 0;
        wave(454, 227, 5);
        chk("t1_note", 32'(note), 1);
        chk("t1_valid", 32'(note_valid), 1);
        chk("t1_period", 32'(period), 454);
        chk("t1_stb", stb_cnt, 1);

        // 2: switch to 523 Hz.
        stb_cnt = 0;
        wave(382, 191, 5);
        chk("t2_note", 32'(note), 3);
        chk("t2_valid", 32'(note_valid), 1);
        chk("t2_period", 32'(period), 382);
        chk("t2_stb", stb_cnt, 1);

        // 3: off-table 600 Hz drops note_valid, no strobe.
        stb_cnt = 0;
        wave(333, 166, 5);
        chk("t3_valid", 32'(note_valid), 0);
        chk("t3_period", 32'(period), 333);
        chk("t3_stb", stb_cnt, 0);

        // 4: lock at 392 Hz, then silence.
        stb_cnt = 0;
        wave(510, 255, 5);
        chk("t4_note", 32'(note), 15);
        chk("t4_valid", 32'(note_valid), 1);
        chk("t4_stb", stb_cnt, 1);
        // Last rise sampled at X; now just past X+509. Drop occurs at X+3+SIL.
        repeat (SIL + LAT - 1 - 509) @(posedge clk);
        #1;
        chk("t4_valid_before_timeout", 32'(note_valid), 1);
        @(posedge clk);
        #1;
        chk("t4_valid_at_timeout", 32'(note_valid), 0);
        repeat (50) @(posedge clk);
        #1;
        stb_cnt = 0;
        wave(454, 227, 2);
        chk("t4_rearm_valid", 32'(note_valid), 0);
        chk("t4_rearm_period", 32'(period), 454);
        chk("t4_rearm_stb", stb_cnt, 0);

        // 5: reset while locked, then relock.
        wave(454, 227, 4);
        chk("t5_locked", 32'(note_valid), 1);
        pulse_rst();
        chk("t5_rst_note", 32'(note), 0);
        chk("t5_rst_valid", 32'(note_valid), 0);
        chk("t5_rst_period", 32'(period), 0);
        stb_cnt = 0;
        wave(454, 227, 4);
        chk("t5_relock_valid", 32'(note_valid), 1);
        chk("t5_relock_note", 32'(note), 1);
        chk("t5_relock_stb", stb_cnt, 1);

        // 6: 440 Hz at 25 % duty.
        pulse_rst();
        stb_cnt = 0;
        wave(454, 113, 5);
`ifdef TONE_DUTY_CHECK_EN
        chk("t6_valid", 32'(note_valid), 0);
        chk("t6_stb", stb_cnt, 0);
`else
        chk("t6_valid", 32'(note_valid), 1);
        chk("t6_note", 32'(note), 1);
        chk("t6_stb", stb_cnt, 1);
`endif
        chk("t6_period", 32'(period), 454);

        repeat (10) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
